// File: rtl/bb84_key_sifter.sv
// ---------------------------------------------------------------------------
// bb84_key_sifter
//
// Purpose:
//   This is the back end of the BB84 receiver. It takes one sifting result per
//   qubit slot and builds the surviving bits into a fixed-length sifted key.
//   Once KEY_LEN bits are collected, the key stays stable until the consumer
//   acknowledges it. The block also counts discarded slots and dropped slots,
//   and flags illegal result codes.
//
// Parameters:
//   KEY_LEN        kept bits per key (>= 2)
//   CNT_W          width of the saturating statistics counters
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   slot_valid     one-cycle pulse; r0/r1/ignore carry a slot result
//   r0, r1, ignore one-hot sifting result (kept 0 / kept 1 / discard)
//   key_ack        consumer has taken the key (only honoured while key_valid)
//   key            assembled key, first kept bit in the MSB
//   key_valid      key complete and held stable
//   bit_count      kept bits in the current key
//   discard_count  ignore slots since reset (saturating)
//   drop_count     legal kept slots lost while holding a key (saturating)
//   code_err       sticky flag: an illegal code arrived on a valid slot
// ---------------------------------------------------------------------------
module bb84_key_sifter #(
  parameter int KEY_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int BC_W   = $clog2(KEY_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               slot_valid,
  input  logic               r0,
  input  logic               r1,
  input  logic               ignore,
  input  logic               key_ack,
  output logic [KEY_LEN-1:0] key,
  output logic               key_valid,
  output logic [BC_W-1:0]    bit_count,
  output logic [CNT_W-1:0]   discard_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               code_err
);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t             state_reg;
  logic [KEY_LEN-1:0] key_reg;
  logic               key_valid_reg;
  logic [BC_W-1:0]    bit_count_reg;
  logic [CNT_W-1:0]   discard_count_reg;
  logic [CNT_W-1:0]   drop_count_reg;
  logic               code_err_reg;

  // Slot decode. Only the three one-hot codes are legal. Every other code
  // on a valid slot is illegal. It is flagged and otherwise ignored.
  logic [2:0] slot_code;
  logic       kept_slot;
  logic       kept_bit;
  logic       discard_slot;
  logic       illegal_slot;
  logic       last_bit;

  always_comb begin
    slot_code    = {r0, r1, ignore};
    kept_slot    = slot_valid && ((slot_code == 3'b100) || (slot_code == 3'b010));
    kept_bit     = r1;
    discard_slot = slot_valid && (slot_code == 3'b001);
    illegal_slot = slot_valid && !kept_slot && !discard_slot;
    // The kept bit arriving now completes the key.
    last_bit     = (bit_count_reg == BC_W'(KEY_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_COLLECT;
      key_reg           <= '0;
      key_valid_reg     <= 1'b0;
      bit_count_reg     <= '0;
      discard_count_reg <= '0;
      drop_count_reg    <= '0;
      code_err_reg      <= 1'b0;
    end else begin
      if (illegal_slot) begin
        code_err_reg <= 1'b1;
      end

      // Discards are counted in both states. The counter sticks at all-ones.
      if (discard_slot && (discard_count_reg != '1)) begin
        discard_count_reg <= discard_count_reg + 1'b1;
      end

      case (state_reg)
        ST_COLLECT: begin
          // key_ack is deliberately ignored here.
          if (kept_slot) begin
            key_reg       <= {key_reg[KEY_LEN-2:0], kept_bit};
            bit_count_reg <= bit_count_reg + 1'b1;
            if (last_bit) begin
              state_reg     <= ST_HOLD;
              key_valid_reg <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          // The key is frozen. A kept slot in this state is lost, even on the
          // ack cycle, so the earliest storable slot is the cycle after the ack.
          if (kept_slot && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + 1'b1;
          end
          if (key_ack) begin
            state_reg     <= ST_COLLECT;
            key_reg       <= '0;
            bit_count_reg <= '0;
            key_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_COLLECT;
        end
      endcase
    end
  end

  assign key           = key_reg;
  assign key_valid     = key_valid_reg;
  assign bit_count     = bit_count_reg;
  assign discard_count = discard_count_reg;
  assign drop_count    = drop_count_reg;
  assign code_err      = code_err_reg;

endmodule
